usr_nbit: RTL and testbench
===========================

# usr_nbit

Parametrised universal shift register: the successor to the fixed-function SISO register in the registers group. It supports hold, shift-right, shift-left and parallel-load modes, with serial input and output at both ends. A frame counter tracks shifts since the last load and pulses when N shifts have completed. It sits between serial links and parallel datapaths, in SIPO, PISO or SISO use.

## Interface
Parameters:
- N, 16, register width in bits; legal range N >= 2.
- CNT_W, $clog2(N+1), frame counter width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_ah_in  input  1  asynchronous, active-high reset.
- en_in  input  1  clock enable; when low, all state holds regardless of mode_in.
- mode_in  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sr_in  input  1  serial input for shift right; enters bit N-1.
- sl_in  input  1  serial input for shift left; enters bit 0.
- d_in  input  N  parallel load data.
- q_out  output  N  register contents.
- so_r_out  output  1  right-shift serial output, equal to q_out[0].
- so_l_out  output  1  left-shift serial output, equal to q_out[N-1].
- cnt_out  output  CNT_W  shifts since last load or frame completion; range 0..N-1.
- frame_out  output  1  one-cycle pulse marking completion of N shifts.

## Operation
- Reset (asynchronous, immediate): q_out=0, cnt_out=0, frame_out=0, so_r_out=0, so_l_out=0.
- Reset mid-operation aborts any frame in progress. No partial state survives.
- When en_in=0, q, cnt and frame all hold; frame_out is forced to 0 on that edge.
- Hold (00): q and cnt unchanged; frame_out cleared.
- Shift right (01): q <= {sr_in, q[N-1:1]}.
- Shift left (10): q <= {q[N-2:0], sl_in}.
- Parallel load (11): q <= d_in; cnt <= 0; frame_out <= 0.
- Shift counting: each enabled shift in either direction increments cnt.
  - When cnt = N-1 and a shift occurs, cnt wraps to 0 and frame_out <= 1.
  - Otherwise frame_out <= 0.
- A direction change mid-frame does not reset cnt; the count is direction-agnostic.
- so_r_out and so_l_out are combinational taps of q, with no extra register stage.
- mode_in is only sampled when en_in=1. Undefined (X) mode is a verification error.

## Timing
- Latency: one cycle from sampled en_in/mode_in/data to q_out. Serial outputs change with q_out.
- frame_out is high for exactly one cycle, the cycle after the N-th shift edge.
  - Back-to-back frames produce pulses N cycles apart under continuous shifting.
- A load on the edge after the N-th shift clears frame_out normally, because the pulse is already registered.
- Parallel-to-serial drain: load, then N shifts; the N original bits appear on so_r_out (right) or so_l_out (left) on successive cycles, the first immediately after the load.

## Configuration
- Macro: USR_NBIT_ROTATE_EN.
- Defined:
  - Adds input port rot_in (1 bit).
  - With rot_in=1, the right shift feeds q[0] into bit N-1 and the left shift feeds q[N-1] into bit 0; sr_in and sl_in are ignored.
  - Rotation still counts toward frames, so after N rotations q equals its post-load value and frame_out pulses.
- Not defined: rot_in does not exist; shifts always take serial inputs.

## Structure
- Package usr_nbit_pkg holds:
  - Mode encoding constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD (2 bits).
  - The mode typedef usr_mode_t.
- Sub-module usr_frame_cnt: CNT_W counter with clear (load), increment (shift), wrap at N-1, and the registered frame pulse.
- The top level holds the data register and the mode mux.

## Test plan
- Reset: assert reset_ah_in mid-shift with q=8'hA5 -> q_out=0, cnt_out=0, frame_out=0 immediately, without waiting for a clock edge.
- SIPO, N=8: shift right with sr_in sequence 1,0,1,1,0,0,1,0 -> q_out=8'h4D after 8 shifts; frame_out high in the following cycle only; cnt_out back to 0.
- PISO, N=8: load 8'hC3, then shift left with sl_in=0 -> so_l_out emits 1,1,0,0,0,0,1,1; q_out=8'h00 after 8 shifts.
- Enable/hold: load 8'h3C, shift 3 times, drop en_in for 5 cycles, shift 5 more -> frame_out pulses only after the 8th enabled shift; q and cnt_out frozen during the gap.
- Load mid-frame: 5 shifts, load 8'hFF, 8 more shifts -> single frame_out pulse after the last shift; cnt_out=0 right after the load.
- USR_NBIT_ROTATE_EN defined: load 8'h81, rotate right with rot_in=1 8 times -> intermediate q=8'hC0 after the first rotation; final q=8'h81 with a frame_out pulse.

Source files
------------

// File: rtl/usr_nbit_pkg.sv
// usr_nbit_pkg: shared mode encoding for the universal shift register.
// Mode constants, mode type and a small decode helper.
package usr_nbit_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } usr_mode_t;

    function automatic logic is_shift(input usr_mode_t m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage

// File: rtl/usr_nbit_frame_cnt.sv
// usr_frame_cnt: direction-agnostic shift counter with frame pulse.
// Clears on load, wraps at N-1 and registers a one-cycle frame pulse.
module usr_frame_cnt #(
    parameter int N     = 16,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset_ah_in,
    input  logic             en_in,
    input  logic             clr_in,
    input  logic             inc_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic             frame_out
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    // Count enabled shifts; pulse frame on the wrap from N-1 to 0.
    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            cnt_out   <= '0;
            frame_out <= 1'b0;
        end else begin
            frame_out <= 1'b0;
            if (en_in) begin
                if (clr_in) begin
                    cnt_out <= '0;
                end else if (inc_in) begin
                    if (cnt_out == LAST) begin
                        cnt_out   <= '0;
                        frame_out <= 1'b1;
                    end else begin
                        cnt_out <= cnt_out + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/usr_nbit.sv
// usr_nbit: N-bit universal shift register (hold/shr/shl/load).
// Optional rotation via rot_in when USR_NBIT_ROTATE_EN is defined.
module usr_nbit
    import usr_nbit_pkg::*;
#(
    parameter int N     = 16,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset_ah_in,
    input  logic             en_in,
    input  logic [1:0]       mode_in,
    input  logic             sr_in,
    input  logic             sl_in,
`ifdef USR_NBIT_ROTATE_EN
    input  logic             rot_in,
`endif
    input  logic [N-1:0]     d_in,
    output logic [N-1:0]     q_out,
    output logic             so_r_out,
    output logic             so_l_out,
    output logic [CNT_W-1:0] cnt_out,
    output logic             frame_out
);

    usr_mode_t  mode;
    logic [N-1:0] q_nxt;
    logic       sr_bit;
    logic       sl_bit;
    logic       shift;
    logic       load;

    assign mode = usr_mode_t'(mode_in);

`ifdef USR_NBIT_ROTATE_EN
    assign sr_bit = rot_in ? q_out[0]   : sr_in;
    assign sl_bit = rot_in ? q_out[N-1] : sl_in;
`else
    assign sr_bit = sr_in;
    assign sl_bit = sl_in;
`endif

    assign so_r_out = q_out[0];
    assign so_l_out = q_out[N-1];

    // Mode mux: next register value and counter control.
    always_comb begin
        q_nxt = q_out;
        shift = is_shift(mode);
        load  = 1'b0;
        unique case (mode)
            MODE_HOLD: q_nxt = q_out;
            MODE_SHR:  q_nxt = {sr_bit, q_out[N-1:1]};
            MODE_SHL:  q_nxt = {q_out[N-2:0], sl_bit};
            MODE_LOAD: begin
                q_nxt = d_in;
                load  = 1'b1;
            end
        endcase
    end

    // Data register; holds whenever the clock enable is low.
    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            q_out <= '0;
        end else if (en_in) begin
            q_out <= q_nxt;
        end
    end

    usr_frame_cnt #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_frame_cnt (
        .clk         (clk),
        .reset_ah_in (reset_ah_in),
        .en_in       (en_in),
        .clr_in      (load),
        .inc_in      (shift),
        .cnt_out     (cnt_out),
        .frame_out   (frame_out)
    );

endmodule

// File: tb/tb_usr_nbit.sv
// tb_usr_nbit: table-driven and scoreboard bench for usr_nbit, N=8.
// Vectors carry expected q/cnt/frame; serial taps derive from q.
module tb_usr_nbit;
    import usr_nbit_pkg::*;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] HLD = MODE_HOLD;
    localparam logic [1:0] SHR = MODE_SHR;
    localparam logic [1:0] SHL = MODE_SHL;
    localparam logic [1:0] LD  = MODE_LOAD;

    logic          clk = 1'b0;
    logic          reset_ah_in;
    logic          en_in;
    logic [1:0]    mode_in;
    logic          sr_in;
    logic          sl_in;
    logic          rot_in;
    logic [N-1:0]  d_in;
    logic [N-1:0]  q_out;
    logic          so_r_out;
    logic          so_l_out;
    logic [CW-1:0] cnt_out;
    logic          frame_out;

    always #5 clk = ~clk;

    usr_nbit #(.N(N)) dut (
        .clk         (clk),
        .reset_ah_in (reset_ah_in),
        .en_in       (en_in),
        .mode_in     (mode_in),
        .sr_in       (sr_in),
        .sl_in       (sl_in),
`ifdef USR_NBIT_ROTATE_EN
        .rot_in      (rot_in),
`endif
        .d_in        (d_in),
        .q_out       (q_out),
        .so_r_out    (so_r_out),
        .so_l_out    (so_l_out),
        .cnt_out     (cnt_out),
        .frame_out   (frame_out)
    );

    typedef struct {
        logic          en;
        logic [1:0]    mode;
        logic          sr;
        logic          sl;
        logic          rot;
        logic [N-1:0]  d;
        logic [N-1:0]  q;
        logic [CW-1:0] cnt;
        logic          fr;
    } vec_t;

    typedef struct {
        logic [N-1:0]  q;
        logic [CW-1:0] cnt;
        logic          fr;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(input logic en, input logic [1:0] mode,
                                input logic sr, input logic sl,
                                input logic rot, input logic [N-1:0] d,
                                input logic [N-1:0] q, input int cnt,
                                input logic fr);
        vec_t v;
        v.en = en; v.mode = mode; v.sr = sr; v.sl = sl; v.rot = rot;
        v.d = d; v.q = q; v.cnt = CW'(cnt); v.fr = fr;
        tbl.push_back(v);
    endfunction

    task automatic check(input string nm, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h",
                     nm, idx, act, exp);
        end
    endtask

    task automatic push_exp(input logic [N-1:0] q, input logic [CW-1:0] c,
                            input logic fr);
        exp_t e;
        e.q = q; e.cnt = c; e.fr = fr;
        sb.push_back(e);
    endtask

    // One clock, then pop the oldest expectation and compare it.
    task automatic step_check(input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", idx, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("q",     idx, 32'(q_out),     32'(e.q));
            check("cnt",   idx, 32'(cnt_out),   32'(e.cnt));
            check("frame", idx, 32'(frame_out), 32'(e.fr));
            check("so_r",  idx, 32'(so_r_out),  32'(e.q[0]));
            check("so_l",  idx, 32'(so_l_out),  32'(e.q[N-1]));
        end
    endtask

    initial begin
        logic [N-1:0] mq;
        int           mcnt;
        logic         mfr;
        int           frames;

        // SIPO right: 1,0,1,1,0,0,1,0 -> 4D
        add(1, SHR, 1, 0, 0, 8'h00, 8'h80, 1, 0);
        add(1, SHR, 0, 0, 0, 8'h00, 8'h40, 2, 0);
        add(1, SHR, 1, 0, 0, 8'h00, 8'hA0, 3, 0);
        add(1, SHR, 1, 0, 0, 8'h00, 8'hD0, 4, 0);
        add(1, SHR, 0, 0, 0, 8'h00, 8'h68, 5, 0);
        add(1, SHR, 0, 0, 0, 8'h00, 8'h34, 6, 0);
        add(1, SHR, 1, 0, 0, 8'h00, 8'h9A, 7, 0);
        add(1, SHR, 0, 0, 0, 8'h00, 8'h4D, 0, 1);
        add(1, HLD, 0, 0, 0, 8'h00, 8'h4D, 0, 0);
        // PISO left from C3
        add(1, LD,  0, 0, 0, 8'hC3, 8'hC3, 0, 0);
        add(1, SHL, 0, 0, 0, 8'h00, 8'h86, 1, 0);
        add(1, SHL, 0, 0, 0, 8'h00, 8'h0C, 2, 0);
        add(1, SHL, 0, 0, 0, 8'h00, 8'h18, 3, 0);
        add(1, SHL, 0, 0, 0, 8'h00, 8'h30, 4, 0);
        add(1, SHL, 0, 0, 0, 8'h00, 8'h60, 5, 0);
        add(1, SHL, 0, 0, 0, 8'h00, 8'hC0, 6, 0);
        add(1, SHL, 0, 0, 0, 8'h00, 8'h80, 7, 0);
        add(1, SHL, 0, 0, 0, 8'h00, 8'h00, 0, 1);
        // load right after the frame edge, then enable gap
        add(1, LD,  0, 0, 0, 8'h3C, 8'h3C, 0, 0);
        add(1, SHR, 0, 0, 0, 8'h00, 8'h1E, 1, 0);
        add(1, SHR, 0, 0, 0, 8'h00, 8'h0F, 2, 0);
        add(1, SHR, 0, 0, 0, 8'h00, 8'h07, 3, 0);
        add(0, SHR, 1, 0, 0, 8'h00, 8'h07, 3, 0);
        add(0, SHR, 1, 0, 0, 8'h00, 8'h07, 3, 0);
        add(0, SHR, 1, 0, 0, 8'h00, 8'h07, 3, 0);
        add(0, LD,  0, 0, 0, 8'h00, 8'h07, 3, 0);
        add(0, SHL, 0, 1, 0, 8'h00, 8'h07, 3, 0);
        add(1, SHR, 1, 0, 0, 8'h00, 8'h83, 4, 0);
        add(1, SHR, 1, 0, 0, 8'h00, 8'hC1, 5, 0);
        add(1, SHR, 1, 0, 0, 8'h00, 8'hE0, 6, 0);
        add(1, SHR, 1, 0, 0, 8'h00, 8'hF0, 7, 0);
        add(1, SHR, 1, 0, 0, 8'h00, 8'hF8, 0, 1);
        add(1, HLD, 0, 0, 0, 8'h00, 8'hF8, 0, 0);
        // load mid-frame, then mixed-direction shifts
        add(1, SHL, 0, 0, 0, 8'h00, 8'hF0, 1, 0);
        add(1, SHL, 0, 0, 0, 8'h00, 8'hE0, 2, 0);
        add(1, SHL, 0, 0, 0, 8'h00, 8'hC0, 3, 0);
        add(1, SHL, 0, 0, 0, 8'h00, 8'h80, 4, 0);
        add(1, SHL, 0, 0, 0, 8'h00, 8'h00, 5, 0);
        add(1, LD,  0, 0, 0, 8'hFF, 8'hFF, 0, 0);
        add(1, SHL, 0, 1, 0, 8'h00, 8'hFF, 1, 0);
        add(1, SHL, 0, 1, 0, 8'h00, 8'hFF, 2, 0);
        add(1, SHL, 0, 1, 0, 8'h00, 8'hFF, 3, 0);
        add(1, SHL, 0, 1, 0, 8'h00, 8'hFF, 4, 0);
        add(1, SHR, 1, 0, 0, 8'h00, 8'hFF, 5, 0);
        add(1, SHR, 1, 0, 0, 8'h00, 8'hFF, 6, 0);
        add(1, SHR, 1, 0, 0, 8'h00, 8'hFF, 7, 0);
        add(1, SHR, 1, 0, 0, 8'h00, 8'hFF, 0, 1);
        add(0, SHR, 0, 0, 0, 8'h00, 8'hFF, 0, 0);
`ifdef USR_NBIT_ROTATE_EN
        // rotate right 8 times from 81, then one rotate left
        add(1, LD,  0, 0, 0, 8'h81, 8'h81, 0, 0);
        add(1, SHR, 0, 0, 1, 8'h00, 8'hC0, 1, 0);
        add(1, SHR, 0, 0, 1, 8'h00, 8'h60, 2, 0);
        add(1, SHR, 0, 0, 1, 8'h00, 8'h30, 3, 0);
        add(1, SHR, 0, 0, 1, 8'h00, 8'h18, 4, 0);
        add(1, SHR, 0, 0, 1, 8'h00, 8'h0C, 5, 0);
        add(1, SHR, 0, 0, 1, 8'h00, 8'h06, 6, 0);
        add(1, SHR, 0, 0, 1, 8'h00, 8'h03, 7, 0);
        add(1, SHR, 0, 0, 1, 8'h00, 8'h81, 0, 1);
        add(1, SHL, 0, 0, 1, 8'h00, 8'h03, 1, 0);
`endif

        reset_ah_in = 1'b1;
        en_in   = 1'b0;
        mode_in = HLD;
        sr_in   = 1'b0;
        sl_in   = 1'b0;
        rot_in  = 1'b0;
        d_in    = '0;
        #2;
        check("rst_q",     -1, 32'(q_out),     32'h0);
        check("rst_cnt",   -1, 32'(cnt_out),   32'h0);
        check("rst_frame", -1, 32'(frame_out), 32'h0);
        check("rst_so_r",  -1, 32'(so_r_out),  32'h0);
        check("rst_so_l",  -1, 32'(so_l_out),  32'h0);
        @(negedge clk);
        reset_ah_in = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            en_in   = tbl[i].en;
            mode_in = tbl[i].mode;
            sr_in   = tbl[i].sr;
            sl_in   = tbl[i].sl;
            rot_in  = tbl[i].rot;
            d_in    = tbl[i].d;
            push_exp(tbl[i].q, tbl[i].cnt, tbl[i].fr);
            step_check(i);
        end

        // Continuous random shifting against a behavioural model.
        rot_in  = 1'b0;
        en_in   = 1'b1;
        mode_in = LD;
        d_in    = '0;
        mq      = '0;
        mcnt    = 0;
        mfr     = 1'b0;
        push_exp(mq, CW'(mcnt), mfr);
        step_check(1000);
        frames = 0;
        for (int i = 0; i < 20; i++) begin
            logic dir;
            logic s;
            dir     = 1'($urandom_range(0, 1));
            s       = 1'($urandom_range(0, 1));
            mode_in = dir ? SHL : SHR;
            sr_in   = s;
            sl_in   = s;
            mq = dir ? {mq[N-2:0], s} : {s, mq[N-1:1]};
            if (mcnt == N - 1) begin
                mcnt = 0;
                mfr  = 1'b1;
            end else begin
                mcnt++;
                mfr = 1'b0;
            end
            push_exp(mq, CW'(mcnt), mfr);
            step_check(1001 + i);
            if (frame_out === 1'b1) frames++;
        end
        check("frame_count", 2000, 32'(frames), 32'd2);

        // Asynchronous reset mid-frame with q = A5.
        mode_in = LD;
        d_in    = 8'h52;
        push_exp(8'h52, '0, 1'b0);
        step_check(3000);
        mode_in = SHL;
        sl_in   = 1'b1;
        push_exp(8'hA5, CW'(1), 1'b0);
        step_check(3001);
        @(negedge clk);
        reset_ah_in = 1'b1;
        #1;
        check("arst_q",     3002, 32'(q_out),     32'h0);
        check("arst_cnt",   3002, 32'(cnt_out),   32'h0);
        check("arst_frame", 3002, 32'(frame_out), 32'h0);
        check("arst_so_l",  3002, 32'(so_l_out),  32'h0);
        @(posedge clk);
        #1;
        check("arst_hold_q", 3003, 32'(q_out), 32'h0);
        reset_ah_in = 1'b0;
        check("sb_drained", 3004, 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
